// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline register chain: EXE/MEM payload layout
// and the helper that sizes the occupancy counter.
package pipe_pkg;

    // EXE/MEM payload layout, MSB first: {WB_EN, MEM_R_EN, MEM_W_EN, ALU_RES, VAL_RM, DEST}
    localparam int WB_EN_BIT     = 70;
    localparam int MEM_R_EN_BIT  = 69;
    localparam int MEM_W_EN_BIT  = 68;
    localparam int ALU_RES_LSB   = 36;
    localparam int ALU_RES_W     = 32;
    localparam int VAL_RM_LSB    = 4;
    localparam int VAL_RM_W      = 32;
    localparam int DEST_LSB      = 0;
    localparam int DEST_W        = 4;
    localparam int EXE_PAYLOAD_W = 71;

    typedef struct packed {
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic [31:0] alu_res;
        logic [31:0] val_rm;
        logic [3:0]  dest;
    } exe_payload_t;

    // Bits needed to count 0..n inclusive (equals $clog2(n+1), minimum 1).
    function automatic int clog2_plus1(input int n);
        int w;
        w = 1;
        while ((1 << w) < (n + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline stage: a valid bit plus a payload register. Loads on adv,
// holds otherwise; flush drops the valid bit but keeps the payload.
module pipe_stage_cell
    import pipe_pkg::*;
#(
    parameter int WIDTH = EXE_PAYLOAD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             flush,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_d;
    logic             valid_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next-state: flush kills the entry, adv loads from upstream, else hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (adv) begin
            valid_d = load_valid;
            data_d  = load_data;
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Stage registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic chain of DEPTH pipeline stages with freeze, flush and valid/ready
// backpressure. Holds the advance/ready chain and the occupancy popcount;
// the storage lives in pipe_stage_cell instances.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH   = EXE_PAYLOAD_W,
    parameter int DEPTH   = 1,
    parameter int ELASTIC = 1,
    localparam int OCC_W  = clog2_plus1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH-1:0] v_s;
    logic [DEPTH-1:0] adv_s;
    logic [DEPTH-1:0] load_v_s;
    logic [WIDTH-1:0] d_s      [DEPTH];
    logic [WIDTH-1:0] load_d_s [DEPTH];
    logic             in_ready_s;
    logic [OCC_W-1:0] occ_s;

    // Advance chain from the output stage back to stage 0. Elastic mode lets a
    // stage move into a bubble even when the output is stalled; rigid mode
    // shifts every stage only when the output stage can move.
    always_comb begin : adv_chain
        logic tail_adv;
        logic run;
        adv_s    = '0;
        tail_adv = ~freeze & (~v_s[DEPTH-1] | out_ready);
        run      = tail_adv;
        adv_s[DEPTH-1] = tail_adv;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            if (ELASTIC != 0) begin
                run = ~freeze & (~v_s[i] | run);
            end else begin
                run = tail_adv;
            end
            adv_s[i] = run;
        end
    end

    assign in_ready_s = adv_s[0] & ~flush;

    // Stage 0 takes the upstream offer; every later stage takes its predecessor.
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign load_v_s[g] = in_valid & in_ready_s;
            assign load_d_s[g] = in_data;
        end else begin : g_body
            assign load_v_s[g] = v_s[g-1];
            assign load_d_s[g] = d_s[g-1];
        end

        pipe_stage_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .adv       (adv_s[g]),
            .flush     (flush),
            .load_valid(load_v_s[g]),
            .load_data (load_d_s[g]),
            .valid     (v_s[g]),
            .data      (d_s[g])
        );
    end

    // Population count of valid stages.
    always_comb begin
        occ_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_s = occ_s + OCC_W'(v_s[i]);
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = v_s[DEPTH-1];
    assign out_data  = d_s[DEPTH-1];
    assign occupancy = occ_s;

endmodule
